// File: rtl/msin_pkg.sv
// Shared constants and routing helper for the 2x2 switch arbiter.
package msin_pkg;

  localparam logic DEST_LEFT    = 1'b0;
  localparam logic DEST_RIGHT   = 1'b1;
  localparam logic SEL_STRAIGHT = 1'b0;
  localparam logic SEL_CROSS    = 1'b1;
  localparam int   DEFAULT_SWITCH_LATENCY = 2;

  // Left input goes straight to left_out; right input goes straight to right_out.
  function automatic logic route_sel(input logic from_right, input logic dest);
    logic sel;
    if (from_right) begin
      sel = (dest == DEST_RIGHT) ? SEL_STRAIGHT : SEL_CROSS;
    end else begin
      sel = (dest == DEST_LEFT) ? SEL_STRAIGHT : SEL_CROSS;
    end
    return sel;
  endfunction

endpackage

// File: rtl/msin_credit_counter.sv
// One downstream credit counter; a credit pulse that would exceed CREDITS
// leaves the count alone and latches a sticky error.
module msin_credit_counter #(
  parameter int CREDITS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dec_i,
  input  logic       inc_i,
  output logic [3:0] count_o,
  output logic       avail_o,
  output logic       err_o
);

  localparam logic [3:0] MAX_CREDITS = 4'(CREDITS);

  logic [3:0] count_q, count_d;
  logic       err_q, err_d;

  // Next count: simultaneous grant and return cancel out.
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    if (dec_i && !inc_i) begin
      count_d = count_q - 4'd1;
    end else if (inc_i && !dec_i) begin
      if (count_q == MAX_CREDITS) begin
        err_d = 1'b1;
      end else begin
        count_d = count_q + 4'd1;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Counter and sticky error state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= MAX_CREDITS;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count_o = count_q;
  assign avail_o = (count_q != 4'd0);
  assign err_o   = err_q;

endmodule

// File: rtl/switch_arbiter_2x2.sv
// Credit-based arbiter driving a 2x2 switch element with round-robin conflict
// resolution. Define SWITCH_ARB_STATS_EN to build the conflict counter.
module switch_arbiter_2x2
  import msin_pkg::*;
#(
  parameter int CREDITS        = 4,
  parameter int SWITCH_LATENCY = DEFAULT_SWITCH_LATENCY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        left_valid,
  input  logic        right_valid,
  input  logic        left_dest,
  input  logic        right_dest,
  output logic        left_grant,
  output logic        right_grant,
  output logic        select,
  output logic        left_out_valid,
  output logic        right_out_valid,
  input  logic        left_credit,
  input  logic        right_credit,
  output logic        credit_err,
  output logic [31:0] conflict_count
);

  logic lo_avail_s, ro_avail_s, lo_err_s, ro_err_s;
  logic lo_dec_s, ro_dec_s;
  logic left_elig_s, right_elig_s, conflict_s;
  logic [3:0] lo_count_s, ro_count_s;
  logic rr_q, rr_d, sel_q, sel_d;
  logic [SWITCH_LATENCY-1:0] lo_pipe_q, lo_pipe_d, ro_pipe_q, ro_pipe_d;

  assign left_elig_s  = left_valid  && ((left_dest  == DEST_LEFT) ? lo_avail_s : ro_avail_s);
  assign right_elig_s = right_valid && ((right_dest == DEST_LEFT) ? lo_avail_s : ro_avail_s);

  // Arbitration: grants are forced low while reset is held.
  always_comb begin
    left_grant  = 1'b0;
    right_grant = 1'b0;
    conflict_s  = 1'b0;
    if (!rst_n) begin
      conflict_s = 1'b0;
    end else if (left_elig_s && right_elig_s && (left_dest == right_dest)) begin
      conflict_s  = 1'b1;
      left_grant  = (rr_q == 1'b0);
      right_grant = (rr_q == 1'b1);
    end else begin
      left_grant  = left_elig_s;
      right_grant = right_elig_s;
    end
    rr_d = conflict_s ? ~rr_q : rr_q;
  end

  // Select follows the granted routing, otherwise replays the held value.
  always_comb begin
    if (left_grant) begin
      sel_d = route_sel(1'b0, left_dest);
    end else if (right_grant) begin
      sel_d = route_sel(1'b1, right_dest);
    end else begin
      sel_d = sel_q;
    end
    select = sel_d;
  end

  assign lo_dec_s = (left_grant && (left_dest == DEST_LEFT))  || (right_grant && (right_dest == DEST_LEFT));
  assign ro_dec_s = (left_grant && (left_dest == DEST_RIGHT)) || (right_grant && (right_dest == DEST_RIGHT));

  // Output-valid shift registers mirror the switch's data latency.
  always_comb begin
    lo_pipe_d    = lo_pipe_q;
    ro_pipe_d    = ro_pipe_q;
    lo_pipe_d[0] = lo_dec_s;
    ro_pipe_d[0] = ro_dec_s;
    for (int i = 1; i < SWITCH_LATENCY; i++) begin
      lo_pipe_d[i] = lo_pipe_q[i-1];
      ro_pipe_d[i] = ro_pipe_q[i-1];
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= 1'b0;
      sel_q     <= SEL_STRAIGHT;
      lo_pipe_q <= '0;
      ro_pipe_q <= '0;
    end else begin
      rr_q      <= rr_d;
      sel_q     <= sel_d;
      lo_pipe_q <= lo_pipe_d;
      ro_pipe_q <= ro_pipe_d;
    end
  end

  assign left_out_valid  = lo_pipe_q[SWITCH_LATENCY-1];
  assign right_out_valid = ro_pipe_q[SWITCH_LATENCY-1];

  msin_credit_counter #(.CREDITS(CREDITS)) u_cred_left (
    .clk(clk), .rst_n(rst_n), .dec_i(lo_dec_s), .inc_i(left_credit),
    .count_o(lo_count_s), .avail_o(lo_avail_s), .err_o(lo_err_s)
  );

  msin_credit_counter #(.CREDITS(CREDITS)) u_cred_right (
    .clk(clk), .rst_n(rst_n), .dec_i(ro_dec_s), .inc_i(right_credit),
    .count_o(ro_count_s), .avail_o(ro_avail_s), .err_o(ro_err_s)
  );

  assign credit_err = lo_err_s | ro_err_s;

`ifdef SWITCH_ARB_STATS_EN
  logic [31:0] conflict_q, conflict_d;

  // Saturating conflict statistics.
  always_comb begin
    if (conflict_s && (conflict_q != 32'hFFFF_FFFF)) begin
      conflict_d = conflict_q + 32'd1;
    end else begin
      conflict_d = conflict_q;
    end
  end

  // Conflict counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= 32'd0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict_count = conflict_q;
`else
  assign conflict_count = 32'd0;
`endif

endmodule

// File: tb/tb_switch_arbiter_2x2.sv
// Scoreboard bench for switch_arbiter_2x2 (CREDITS=4, SWITCH_LATENCY=2).
module tb_switch_arbiter_2x2;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic left_valid = 1'b0, right_valid = 1'b0, left_dest = 1'b0, right_dest = 1'b0;
  logic left_credit = 1'b0, right_credit = 1'b0;
  logic left_grant, right_grant, select, left_out_valid, right_out_valid, credit_err;
  logic [31:0] conflict_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int   cyc;
    logic lg;
    logic rg;
    logic sel;
  } gexp_t;

  gexp_t gq[$];
  int    lq[$];
  int    rq[$];

  switch_arbiter_2x2 #(.CREDITS(4), .SWITCH_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .left_valid(left_valid), .right_valid(right_valid),
    .left_dest(left_dest), .right_dest(right_dest),
    .left_grant(left_grant), .right_grant(right_grant), .select(select),
    .left_out_valid(left_out_valid), .right_out_valid(right_out_valid),
    .left_credit(left_credit), .right_credit(right_credit),
    .credit_err(credit_err), .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic lv, input logic ld, input logic rv, input logic rd,
                       input logic lc, input logic rc);
    left_valid = lv; left_dest = ld; right_valid = rv; right_dest = rd;
    left_credit = lc; right_credit = rc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_grant(input logic lg, input logic rg, input logic sel);
    gexp_t e;
    e.cyc = cyc; e.lg = lg; e.rg = rg; e.sel = sel;
    gq.push_back(e);
  endtask

  // Monitor: every DUT grant or output-valid is matched against the scoreboard.
  always @(negedge clk) begin
    if (left_grant || right_grant) begin
      gexp_t e;
      tests++;
      if (gq.size() == 0) begin
        fails++;
        $display("FAIL grant_unexpected: got lg=%0b rg=%0b sel=%0b at cycle %0d, expected none",
                 left_grant, right_grant, select, cyc);
      end else begin
        e = gq.pop_front();
        if (e.cyc != cyc || e.lg !== left_grant || e.rg !== right_grant || e.sel !== select) begin
          fails++;
          $display("FAIL grant: got cyc=%0d lg=%0b rg=%0b sel=%0b expected cyc=%0d lg=%0b rg=%0b sel=%0b",
                   cyc, left_grant, right_grant, select, e.cyc, e.lg, e.rg, e.sel);
        end
      end
    end
    if (left_out_valid) begin
      tests++;
      if (lq.size() == 0) begin
        fails++;
        $display("FAIL left_out_valid_unexpected: got 1 at cycle %0d expected 0", cyc);
      end else begin
        int c;
        c = lq.pop_front();
        if (c != cyc) begin
          fails++;
          $display("FAIL left_out_valid: got cycle %0d expected cycle %0d", cyc, c);
        end
      end
    end
    if (right_out_valid) begin
      tests++;
      if (rq.size() == 0) begin
        fails++;
        $display("FAIL right_out_valid_unexpected: got 1 at cycle %0d expected 0", cyc);
      end else begin
        int c;
        c = rq.pop_front();
        if (c != cyc) begin
          fails++;
          $display("FAIL right_out_valid: got cycle %0d expected cycle %0d", cyc, c);
        end
      end
    end
  end

  initial begin
    int exp_cc;
    // Reset held with requests present: nothing may be granted.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_left_grant", {31'd0, left_grant}, 32'd0);
    chk("rst_right_grant", {31'd0, right_grant}, 32'd0);
    chk("rst_select", {31'd0, select}, 32'd0);
    chk("rst_credit_err", {31'd0, credit_err}, 32'd0);
    chk("rst_conflict_count", conflict_count, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Left only to right_out: cross.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_grant(1'b1, 1'b0, 1'b1); rq.push_back(cyc + LAT);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_right_count", {28'd0, dut.u_cred_right.count_o}, 32'd4);
    tick();

    // Different destinations, straight: both granted.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_grant(1'b1, 1'b1, 1'b0); lq.push_back(cyc + LAT); rq.push_back(cyc + LAT);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Cross grant then idle: select must hold 1.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_grant(1'b1, 1'b0, 1'b1); rq.push_back(cyc + LAT);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_select_hold", {31'd0, select}, 32'd1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t3_right_count", {28'd0, dut.u_cred_right.count_o}, 32'd4);
    tick();

    // Same destination for five cycles: L,R,L,R then credits exhausted.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) exp_grant(1'b1, 1'b0, 1'b1);
      else            exp_grant(1'b0, 1'b1, 1'b0);
      rq.push_back(cyc + LAT);
      tick();
    end
    @(negedge clk);
    chk("exhausted_select_hold", {31'd0, select}, 32'd0);
    chk("exhausted_right_count", {28'd0, dut.u_cred_right.count_o}, 32'd0);
`ifdef SWITCH_ARB_STATS_EN
    exp_cc = 4;
`else
    exp_cc = 0;
`endif
    chk("conflict_count", conflict_count, 32'(exp_cc));
    tick();

    // Restore right credits to 2, then grant and credit in the same cycle.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_grant(1'b1, 1'b0, 1'b1); rq.push_back(cyc + LAT);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("grant_and_credit_count", {28'd0, dut.u_cred_right.count_o}, 32'd2);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_no_err", {31'd0, credit_err}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("overflow_err", {31'd0, credit_err}, 32'd1);
    chk("overflow_count_hold", {28'd0, dut.u_cred_right.count_o}, 32'd4);
    tick();
    tick();
    @(negedge clk);
    chk("err_sticky", {31'd0, credit_err}, 32'd1);
    tick();

    // Conflict grant, then reset one cycle later discards the in-flight valid.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_grant(1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    chk("post_rst_left_count", {28'd0, dut.u_cred_left.count_o}, 32'd4);
    chk("post_rst_right_count", {28'd0, dut.u_cred_right.count_o}, 32'd4);
    chk("post_rst_rr", {31'd0, dut.rr_q}, 32'd0);
    chk("post_rst_credit_err", {31'd0, credit_err}, 32'd0);
    chk("post_rst_conflict_count", conflict_count, 32'd0);
    tick();

    for (int i = 0; i < 4; i++) tick();
    chk("grant_queue_empty", 32'(gq.size()), 32'd0);
    chk("left_valid_queue_empty", 32'(lq.size()), 32'd0);
    chk("right_valid_queue_empty", 32'(rq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
